// File: rtl/lsu_ctrl_if.sv
// Bus bundle for lsu_ctrl: execute-stage request, response channel and the
// data-memory port. The "slave" modport is the LSU's view; "master" is the
// surrounding core and memory.
interface lsu_ctrl_if;
  // request channel
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  // response channel
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  // memory port
  logic        mem_valid;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;

  modport slave (
    input  in_valid, in_is_store, in_funct3, in_addr, in_wdata,
    input  out_ready, mem_read_data,
    output in_ready, out_valid, out_rdata, out_err,
    output mem_valid, mem_write_enable, mem_write_addr, mem_write_data,
    output mem_write_mask, mem_read_addr
  );

  modport master (
    output in_valid, in_is_store, in_funct3, in_addr, in_wdata,
    output out_ready, mem_read_data,
    input  in_ready, out_valid, out_rdata, out_err,
    input  mem_valid, mem_write_enable, mem_write_addr, mem_write_data,
    input  mem_write_mask, mem_read_addr
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: takes one RV32 load/store at a time, performs a single
// word-aligned memory access with byte mask and lane-shifted store data, and
// returns extended load data (or an error flag) over a valid/ready response.
module lsu_ctrl #(
  parameter int unsigned LATENCY = 0  // extra wait cycles after the access, 0..15
) (
  input  logic       clock,
  input  logic       reset,           // asynchronous, active low
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] data_q;
  logic        out_valid_q;
  logic        out_err_q;
  logic [31:0] out_rdata_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_mask_q;

  // Illegal width code, store of an unsigned width, or misaligned access.
  // NOTE: a function that returns on every path describes pure logic; no storage is implied.
  function automatic logic req_illegal(input logic st, input logic [2:0] f3,
                                       input logic [1:0] off);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return off[0];
      3'b010:  return off != 2'b00;
      3'b100:  return st;
      3'b101:  return st | off[0];
      default: return 1'b1;
    endcase
  endfunction

  // Byte enables for the accessed lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Pull the addressed byte/half out of the word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] data, input logic [2:0] f3,
                                          input logic [1:0] off, input logic st);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    if (st) return 32'd0;
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return data;
    endcase
  endfunction

  // Request FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: datapath registers are reset as well; there is no RAM here, so defined outputs cost nothing.
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      data_q      <= 32'd0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_mask_q  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            is_store_q <= bus.in_is_store;
            funct3_q   <= bus.in_funct3;
            off_q      <= bus.in_addr[1:0];
            if (req_illegal(bus.in_is_store, bus.in_funct3, bus.in_addr[1:0])) begin
              state       <= RESP;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_rdata_q <= 32'd0;
            end else begin
              state       <= ACCESS;
              mem_valid_q <= 1'b1;
              mem_we_q    <= bus.in_is_store;
              mem_addr_q  <= {bus.in_addr[31:2], 2'b00};
              mem_wdata_q <= bus.in_wdata << {bus.in_addr[1:0], 3'b000};
              mem_mask_q  <= lane_mask(bus.in_funct3, bus.in_addr[1:0]);
            end
          end
        end
        ACCESS: begin
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          data_q      <= bus.mem_read_data;
          if (LATENCY > 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end else begin
            state       <= RESP;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_rdata_q <= extract(bus.mem_read_data, funct3_q, off_q, is_store_q);
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= RESP;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_rdata_q <= extract(data_q, funct3_q, off_q, is_store_q);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready         = (state == IDLE);
  assign bus.out_valid        = out_valid_q;
  assign bus.out_err          = out_err_q;
  assign bus.out_rdata        = out_rdata_q;
  assign bus.mem_valid        = mem_valid_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_write_addr   = mem_addr_q;
  assign bus.mem_read_addr    = mem_addr_q;
  assign bus.mem_write_data   = mem_wdata_q;
  assign bus.mem_write_mask   = mem_mask_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit that sits directly upstream of the DPI data-memory port. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It converts each request into a single-cycle memory access with a word-aligned address, byte mask and shifted write data. It returns aligned, sign- or zero-extended load data, or an error flag, over a second valid/ready handshake.

Parameters:
LATENCY, 0, extra wait cycles inserted after the memory access before the response (models slower memory); legal range 0..15.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  high only in IDLE
in_is_store  input  1  1 = store, 0 = load
in_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  input  32  byte address
in_wdata  input  32  store data, right-justified
out_valid  output  1  response valid
out_ready  input  1  response accepted
out_rdata  output  32  extended load data; 0 for stores and errors
out_err  output  1  misaligned or illegal funct3
mem_valid  output  1  memory access strobe
mem_write_enable  output  1  store strobe, only with mem_valid
mem_write_addr  output  32  {addr[31:2],2'b00}
mem_write_data  output  32  in_wdata shifted left by 8*addr[1:0]
mem_write_mask  output  4  byte enables
mem_read_addr  output  32  {addr[31:2],2'b00}
mem_read_data  input  32  combinational read data, valid while mem_valid=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out_valid=0, out_rdata=0, out_err=0.
  - mem_valid=0, mem_write_enable=0, mem_write_mask=0, wait counter=0.
  - Any in-flight request is dropped. No memory write may occur after reset asserts.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - in_ready=1. On in_valid, register is_store, funct3, addr and wdata.
  - Legal request -> ACCESS. Error -> RESP with out_err=1 and out_rdata=0; no memory access is made.
- Error conditions:
  - funct3 not in {000,001,010,100,101}.
  - Store with funct3 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
- ACCESS (exactly one cycle):
  - mem_valid=1; mem_write_enable=is_store.
  - Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
  - At the closing edge, register mem_read_data into a data holding register.
  - Next state: WAIT if LATENCY>0, else RESP.
- Memory outputs outside ACCESS:
  - mem_valid=0 and mem_write_enable=0.
  - Address, data and mask outputs hold their registered values and must not toggle during ACCESS.
- WAIT:
  - Counter loads LATENCY-1 on entry and decrements each cycle.
  - When the counter is 0 -> RESP. Total WAIT duration is LATENCY cycles.
- RESP:
  - out_valid=1; out_rdata and out_err are stable until out_valid && out_ready, then -> IDLE.
  - out_valid drops in the cycle after acceptance.
- Load extraction: byte = data>>(8*addr[1:0]), half = data>>(8*addr[1:0]).
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes data through.
  - Stores return out_rdata=0.
- Latency: handshake at edge T; ACCESS during cycle T+1; out_valid high in cycle T+2+LATENCY.
- Backpressure: out_ready may stay low indefinitely. No new request is accepted until the response is taken (in_ready=0 outside IDLE).
- Throughput: one request per 3+LATENCY cycles with out_ready held high.
- Inputs are ignored outside IDLE. Address arithmetic is 32-bit; there is no wrap handling.

Test Plan:
- Load word: LATENCY=0; load W addr 0x80000004, memory word 0xDEADBEEF -> mem_valid high one cycle, mem_read_addr 0x80000004; out_valid two cycles after handshake, out_rdata 0xDEADBEEF, out_err 0.
- Sub-word loads: memory 0x80F17F01 at 0x80000000 -> B@+3 = 0xFFFFFF80; BU@+3 = 0x00000080; H@+2 = 0xFFFF80F1; HU@+2 = 0x000080F1; B@+1 = 0x0000007F.
- Stores:
  - SB addr 0x80000003, wdata 0x000000AB -> mask 1000, mem_write_data 0xAB000000, mem_write_addr 0x80000000, mem_write_enable high one cycle.
  - SH @+2, wdata 0x1234 -> mask 1100, data 0x12340000.
- Errors: LW addr 0x80000002, SH addr 0x80000001, load funct3 011 -> mem_valid never asserts; out_err 1, out_rdata 0, out_valid one cycle after handshake.
- Backpressure and latency: LATENCY=3, out_ready low 5 cycles -> out_valid at T+5 and held with stable data; in_ready low throughout; IDLE is reached the cycle after out_ready rises.
- Reset mid-operation: reset=0 asserted in the WAIT state -> out_valid, mem_valid and mem_write_enable go 0 immediately; after release in_ready=1 and no response is emitted for the aborted request.
